// File: rtl/dmem_read_responder.sv
// Slow data memory answering Beta cache misses with a programmable latency
// and a four-phase MemRead / MemReadReady / MemReadDone handshake.
//
// state    | meaning
// sIdle    | no read pending; waiting for an uncached MemRead
// sWait    | latency counter running toward the data snapshot
// sReady   | MemReadReady high, snapshot data held on memReadData
// sRelease | Done seen; waiting for MemReadDone to drop before re-accepting
module dmem_read_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           memAddr,
    input  logic [DATA_WIDTH-1:0] memWriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  MemHit,
    input  logic                  MemReadDone,
    input  logic [3:0]            lat,
    output logic [DATA_WIDTH-1:0] memReadData,
    output logic                  MemReadReady,
    output logic                  busy
);

    typedef enum logic [1:0] {
        sIdle    = 2'd0,
        sWait    = 2'd1,
        sReady   = 2'd2,
        sRelease = 2'd3
    } state_t;

    state_t                state;
    state_t                nextState;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] dataReg;
    logic [IDX_WIDTH-1:0]  addrIdx;
    logic [IDX_WIDTH-1:0]  latIdx;
    logic [3:0]            cnt;
    logic [3:0]            latLoad;
    logic                  accept;
    logic                  snapshot;
    logic                  unusedAddr;

    // Only the word index matters; byte offset and high bits alias.
    assign addrIdx    = memAddr[IDX_WIDTH+1:2];
    assign unusedAddr = ^{memAddr[31:IDX_WIDTH+2], memAddr[1:0]};
    assign latLoad    = (lat <= 4'd1) ? 4'd1 : lat;
    assign accept     = (state == sIdle) && (nextState == sWait);
    assign snapshot   = (state == sWait) && (nextState == sReady);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= sIdle;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            sIdle: begin
                if (MemRead && !MemHit && !MemWrite) begin
                    nextState = sWait;
                end
            end
            sWait: begin
                if (!MemRead) begin
                    nextState = sIdle;
                end else if (cnt == 4'd1) begin
                    nextState = sReady;
                end
            end
            sReady: begin
                if (MemReadDone) begin
                    nextState = sRelease;
                end else if (!MemRead) begin
                    nextState = sIdle;
                end
            end
            sRelease: begin
                if (!MemReadDone) begin
                    nextState = sIdle;
                end
            end
            default: nextState = sIdle;
        endcase
    end

    always_comb begin
        MemReadReady = 1'b0;
        memReadData  = '0;
        busy         = (state != sIdle);
        if (state == sReady) begin
            MemReadReady = 1'b1;
            memReadData  = dataReg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 4'd0;
            latIdx  <= '0;
            dataReg <= '0;
        end else begin
            if (accept) begin
                cnt    <= latLoad;
                latIdx <= addrIdx;
            end else if (state == sWait) begin
                cnt <= cnt - 4'd1;
            end
            // Non-blocking read here sees the pre-write word on a same-edge write.
            if (snapshot) begin
                dataReg <= mem[latIdx];
            end
        end
    end

    // Storage deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (MemWrite) begin
            mem[addrIdx] <= memWriteData;
        end
    end

endmodule

// File: doc/dmem_read_responder.md
Name: dmem_read_responder

Overview:
- Memory-side responder for the Beta data-memory read handshake (MemRead / MemReadReady / MemReadDone).
- Synthesizable slow data memory that serves Beta cache misses after a programmable latency, using a four-phase ready/done handshake.
- Accepts single-cycle writes.
- Sits between the beta core and backing storage; replaces the behavioural bench delay loop.

Parameters:
- DATA_WIDTH, 32, data word width.
- MEM_WORDS, 256, number of storage words; a power of 2.
- IDX_WIDTH, 8, log2(MEM_WORDS); word index = memAddr[IDX_WIDTH+1:2].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- memAddr  input  32  byte address from beta; bits [1:0] ignored; upper bits above the index ignored (wrap).
- memWriteData  input  DATA_WIDTH  write data.
- MemWrite  input  1  write strobe; one word written per cycle while high.
- MemRead  input  1  read request level from beta.
- MemHit  input  1  beta cache hit; when high the request is served by the cache and ignored here.
- MemReadDone  input  1  beta has captured memReadData.
- lat  input  4  response latency in cycles; sampled at accept; 0 and 1 treated as 1.
- memReadData  output  DATA_WIDTH  read data; valid only while MemReadReady=1, else 0.
- MemReadReady  output  1  read data valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State becomes IDLE.
  - MemReadReady=0, memReadData=0, busy=0, counter=0, latched index=0.
  - Storage contents are not cleared.
- Reset mid-transaction aborts immediately; no ready pulse follows after release.
- States: IDLE, WAIT, READY, RELEASE.
- IDLE:
  - Accept when MemRead=1 & MemHit=0 & MemWrite=0 at a rising edge.
  - On accept: latch word index, load counter with max(lat,1), go to WAIT.
  - MemRead with MemHit=1, or MemRead together with MemWrite, is not accepted.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter==1: register memReadData = mem[latched index], set MemReadReady=1, go to READY.
  - Latency from the accept edge to MemReadReady high is exactly max(lat,1) edges.
  - MemRead=0 in WAIT: abort to IDLE next edge; MemReadReady stays 0.
- READY:
  - MemReadReady=1 and memReadData held stable.
  - MemReadDone=1 sampled at an edge: MemReadReady=0 and memReadData=0 at that edge, go to RELEASE.
  - MemRead=0 without MemReadDone: abort to IDLE with MemReadReady=0.
- RELEASE:
  - Stays here while MemReadDone=1; returns to IDLE on the first edge with MemReadDone=0.
  - Four-phase handshake: no new request is accepted until Done has dropped.
  - Earliest re-accept is the edge after the return to IDLE.
- Writes:
  - MemWrite=1 at an edge writes mem[index(memAddr)] = memWriteData in any state, including during a pending read.
  - Read data is snapshotted at the WAIT->READY edge. A write to the same index before that edge is visible. A write on or after that edge is not visible in the held data.
  - On the snapshot edge itself, the old value is returned (read-before-write).
- Address wrap: index uses low bits only, so memAddr=0x400 aliases to 0x000 for MEM_WORDS=256.
- MemReadDone high while in IDLE or WAIT is ignored.

Test Plan:
- Reset, then mem[3]=0xDEADBEEF via write at 0x0C; lat=4, MemRead at 0x0C, MemHit=0 -> MemReadReady rises exactly 4 edges after accept with memReadData=0xDEADBEEF; Done=1 -> Ready=0 next edge; Done=0 -> IDLE, busy=0.
- lat=0 and lat=1 -> Ready 1 edge after accept; lat=15 -> 15 edges; MemHit=1 with MemRead=1 -> state remains IDLE, busy=0, no Ready.
- Pending read of 0x10, lat=6; write 0x12345678 to 0x10 at edge 3 -> returns 0x12345678. Repeat with the write during READY -> returns the old value and data stays stable until Done.
- MemRead dropped at WAIT edge 2 -> IDLE, Ready never asserted. Done held high 3 cycles -> stays in RELEASE 3 cycles, and a MemRead during that time is not accepted until Done=0.
- reset pulled low mid-WAIT and mid-READY -> MemReadReady/memReadData/busy go to 0 immediately (asynchronously), storage is preserved, and a subsequent read returns the stored data.
- Address alias: write 0xA5A5A5A5 to 0x404 -> read at 0x004 returns 0xA5A5A5A5; back-to-back reads of 0x00..0x1C return the written pattern with no lost handshakes.
